// File: rtl/shadow_read_arbiter.sv
// Read-port arbiter for the BSRAM video shadow memory: fixed-priority video with a VGC starvation guard.
// Optional statistics ports are built in when SHADOW_ARB_STATS_EN is defined.
module shadow_read_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        vgc_active_i,
    input  logic        video_req_i,
    input  logic [15:0] video_addr_i,
    output logic        video_gnt_o,
    output logic        video_valid_o,
    output logic [31:0] video_data_o,
    input  logic        vgc_req_i,
    input  logic [12:0] vgc_addr_i,
    output logic        vgc_gnt_o,
    output logic        vgc_valid_o,
    output logic [31:0] vgc_data_o,
    output logic        mem_rd_o,
    output logic        mem_vgc_sel_o,
    output logic [15:0] mem_addr_o,
    input  logic [31:0] mem_data_i
`ifdef SHADOW_ARB_STATS_EN
    ,
    input  logic        stat_clear_i,
    output logic [15:0] stat_video_grants_o,
    output logic [15:0] stat_vgc_grants_o,
    output logic [7:0]  stat_max_wait_o,
    output logic [15:0] stat_override_o
`endif
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic                    vgc_elig;
    logic                    override;
    logic                    video_gnt;
    logic                    vgc_gnt;
    logic [7:0]              wait_cnt;
    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_s;
    logic                    ret_video;
    logic                    ret_vgc;

    // Grants are suppressed while reset is held so every output reads 0 during reset.
    always_comb begin
        vgc_elig  = vgc_req_i && vgc_active_i;
        override  = (MAX_W != 8'd0) && (wait_cnt == MAX_W) && vgc_elig;
        video_gnt = 1'b0;
        vgc_gnt   = 1'b0;
        if (system_reset_n) begin
            if (override)
                vgc_gnt = 1'b1;
            else if (video_req_i)
                video_gnt = 1'b1;
            else if (vgc_elig)
                vgc_gnt = 1'b1;
        end
    end

    assign video_gnt_o = video_gnt;
    assign vgc_gnt_o   = vgc_gnt;
    assign ret_video   = tag_v[READ_LATENCY-1] && !tag_s[READ_LATENCY-1];
    assign ret_vgc     = tag_v[READ_LATENCY-1] &&  tag_s[READ_LATENCY-1];

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            wait_cnt      <= '0;
            mem_rd_o      <= 1'b0;
            mem_vgc_sel_o <= 1'b0;
            mem_addr_o    <= '0;
            tag_v         <= '0;
            tag_s         <= '0;
            video_valid_o <= 1'b0;
            video_data_o  <= '0;
            vgc_valid_o   <= 1'b0;
            vgc_data_o    <= '0;
        end else begin
            if (vgc_gnt || !vgc_elig)
                wait_cnt <= '0;
            else if (wait_cnt != MAX_W)
                wait_cnt <= wait_cnt + 8'd1;

            mem_rd_o <= video_gnt || vgc_gnt;
            if (video_gnt) begin
                mem_addr_o    <= video_addr_i;
                mem_vgc_sel_o <= 1'b0;
            end else if (vgc_gnt) begin
                mem_addr_o    <= {3'b000, vgc_addr_i};
                mem_vgc_sel_o <= 1'b1;
            end

            // Tag stage READ_LATENCY-1 lines up with the cycle mem_data_i is valid.
            tag_v[0] <= mem_rd_o;
            tag_s[0] <= mem_vgc_sel_o;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_s[i] <= tag_s[i-1];
            end

            video_valid_o <= ret_video;
            vgc_valid_o   <= ret_vgc;
            if (ret_video)
                video_data_o <= mem_data_i;
            if (ret_vgc)
                vgc_data_o <= mem_data_i;
        end
    end

`ifdef SHADOW_ARB_STATS_EN
    always_ff @(posedge clk_logic) begin
        if (!system_reset_n || stat_clear_i) begin
            stat_video_grants_o <= '0;
            stat_vgc_grants_o   <= '0;
            stat_max_wait_o     <= '0;
            stat_override_o     <= '0;
        end else begin
            if (video_gnt && stat_video_grants_o != '1)
                stat_video_grants_o <= stat_video_grants_o + 16'd1;
            if (vgc_gnt && stat_vgc_grants_o != '1)
                stat_vgc_grants_o <= stat_vgc_grants_o + 16'd1;
            if (override && stat_override_o != '1)
                stat_override_o <= stat_override_o + 16'd1;
            if (wait_cnt > stat_max_wait_o)
                stat_max_wait_o <= wait_cnt;
        end
    end
`endif

endmodule
